relu_backward: RTL and testbench
================================

RELU_BACKWARD -- requirements
Module: relu_backward

Interface
REQ-001 SHALL have parameter WIDTH, default 8: forward activation half-width; forward data is 4*WIDTH bits, gradients are 2*WIDTH bits.
REQ-002 SHALL have parameter DEPTH, default 16, power of two >= 2: number of stored mask bits.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port clear  input  1  synchronous flush of stored masks and output register.
REQ-006 SHALL have port fwd_valid  input  1  forward pre-activation sample present.
REQ-007 SHALL have port fwd_ready  output  1  mask store can accept a sample.
REQ-008 SHALL have port fwd_data  input  4*WIDTH signed  forward pre-activation accumulator value.
REQ-009 SHALL have port grad_in_valid  input  1  upstream gradient present.
REQ-010 SHALL have port grad_in_ready  output  1  gradient accepted this cycle.
REQ-011 SHALL have port grad_in  input  2*WIDTH signed  upstream gradient.
REQ-012 SHALL have port grad_out_valid  output  1  gated gradient present.
REQ-013 SHALL have port grad_out_ready  input  1  downstream accepts gradient.
REQ-014 SHALL have port grad_out  output  2*WIDTH signed  gated gradient.
REQ-015 SHALL have port mask_count  output  $clog2(DEPTH)+1  stored mask bits.

Function
REQ-016 A forward transfer (fwd_valid && fwd_ready) SHALL push one mask bit: 1 iff fwd_data > 0 (signed), 0 for zero or negative.
REQ-017 fwd_ready SHALL equal (mask_count != DEPTH) && !clear.
REQ-018 A gradient transfer (grad_in_valid && grad_in_ready) SHALL pop the oldest mask bit (FIFO order).
REQ-019 grad_in_ready SHALL equal (mask_count != 0) && (!grad_out_valid || grad_out_ready) && !clear.
REQ-020 On a gradient transfer, grad_out SHALL register grad_in if the popped mask is 1, else 0; grad_out_valid SHALL be set the next cycle (latency 1).
REQ-021 grad_out SHALL NOT be scaled; sign and width are preserved exactly.
REQ-022 grad_out_valid SHALL clear when grad_out_ready is high and no new transfer occurs; grad_out and grad_out_valid SHALL hold while grad_out_valid && !grad_out_ready.
REQ-023 Simultaneous push and pop SHALL leave mask_count unchanged and keep order; a bit pushed while empty SHALL NOT be poppable in the same cycle (no bypass).
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; mask_count SHALL never exceed DEPTH or fall below 0.
REQ-025 clear SHALL take priority over all transfers: next cycle mask_count=0, pointers=0, grad_out_valid=0.

Reset
REQ-026 While rst_n is low: mask_count=0, pointers=0, grad_out_valid=0, grad_out=0; fwd_ready and grad_in_ready SHALL be 0 during reset.
REQ-027 Reset asserted mid-operation SHALL discard all stored masks and any pending output with no partial transfer.
REQ-028 Mask storage contents need not be reset; only pointers and count.

Structure
REQ-029 A shared package SHALL hold the default WIDTH and DEPTH constants used by the dense-layer blocks.
REQ-030 Mask storage SHALL be a 1-bit-wide sub-module mask_fifo (push, pop, full, empty, count); gating and output register stay in relu_backward.

Verification (WIDTH=8, DEPTH=16)
REQ-031 Push fwd_data 100, -5, 0, 300; then grad_in 7, 7, 7, 7 with grad_out_ready=1 -> grad_out 7, 0, 0, 7, each 1 cycle after acceptance.
REQ-032 Push 16 positives -> fwd_ready=0, mask_count=16; 17th fwd_valid is not accepted; one pop -> fwd_ready=1 next cycle.
REQ-033 grad_in_valid=1 while mask_count=0 -> grad_in_ready=0, grad_out_valid stays 0; push one bit -> transfer in the following cycle, not the same one.
REQ-034 Hold grad_out_ready=0 with grad_out=-1234 valid -> grad_out stable, grad_in_ready=0; release -> next gradient accepted that cycle.
REQ-035 Push 40 and pop 40 with simultaneous push/pop -> pointers wrap, masks match forward order, mask_count never exceeds 16.
REQ-036 Assert clear, or drop rst_n, with mask_count=5 and grad_out_valid=1 -> mask_count=0, grad_out_valid=0; subsequent gradients stall until new pushes.

Source files
------------

// File: rtl/relu_backward_pkg.sv
// Shared constants for the dense-layer datapath blocks.
package relu_backward_pkg;
   localparam int DENSE_WIDTH = 8;
   localparam int DENSE_DEPTH = 16;
endpackage

// File: rtl/mask_fifo.sv
// One-bit-wide FIFO holding ReLU masks between the forward and backward passes.
module mask_fifo
   import relu_backward_pkg::*;
#(
   parameter int DEPTH = DENSE_DEPTH,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic          din,
   output logic          dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // storage is not reset; only the pointers and count define what is valid
   always_ff @(posedge clk) begin
      if (push_ok && !clear) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/relu_backward.sv
// ReLU backward pass: records forward sign masks, then gates upstream gradients in order.
module relu_backward
   import relu_backward_pkg::*;
#(
   parameter int WIDTH = DENSE_WIDTH,
   parameter int DEPTH = DENSE_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        fwd_valid,
   output logic                        fwd_ready,
   input  logic signed [4*WIDTH-1:0]   fwd_data,
   input  logic                        grad_in_valid,
   output logic                        grad_in_ready,
   input  logic signed [2*WIDTH-1:0]   grad_in,
   output logic                        grad_out_valid,
   input  logic                        grad_out_ready,
   output logic signed [2*WIDTH-1:0]   grad_out,
   output logic [$clog2(DEPTH):0]      mask_count
);

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic fwd_pos;
   logic mask_bit;

   // strictly positive: sign bit clear and not zero
   assign fwd_pos = !fwd_data[4*WIDTH-1] && (fwd_data != '0);

   assign fwd_ready     = rst_n && !full && !clear;
   assign grad_in_ready = rst_n && !empty && (!grad_out_valid || grad_out_ready) && !clear;
   assign push          = fwd_valid && fwd_ready;
   assign pop           = grad_in_valid && grad_in_ready;

   mask_fifo #(.DEPTH(DEPTH)) u_mask_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .din   (fwd_pos),
      .dout  (mask_bit),
      .full  (full),
      .empty (empty),
      .count (mask_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grad_out_valid <= 1'b0;
         grad_out       <= '0;
      end else if (clear) begin
         grad_out_valid <= 1'b0;
         grad_out       <= '0;
      end else if (pop) begin
         grad_out_valid <= 1'b1;
         grad_out       <= mask_bit ? grad_in : '0;
      end else if (grad_out_ready) begin
         grad_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_relu_backward.sv
// Self-checking bench for relu_backward against a queue-based reference model.
module tb_relu_backward;
   localparam int W = 8;
   localparam int D = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic fwd_valid = 1'b0;
   logic grad_in_valid = 1'b0;
   logic grad_out_ready = 1'b0;
   logic signed [4*W-1:0] fwd_data = '0;
   logic signed [2*W-1:0] grad_in = '0;
   logic fwd_ready;
   logic grad_in_ready;
   logic grad_out_valid;
   logic signed [2*W-1:0] grad_out;
   logic [$clog2(D):0] mask_count;

   relu_backward #(.WIDTH(W), .DEPTH(D)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear          (clear),
      .fwd_valid      (fwd_valid),
      .fwd_ready      (fwd_ready),
      .fwd_data       (fwd_data),
      .grad_in_valid  (grad_in_valid),
      .grad_in_ready  (grad_in_ready),
      .grad_in        (grad_in),
      .grad_out_valid (grad_out_valid),
      .grad_out_ready (grad_out_ready),
      .grad_out       (grad_out),
      .mask_count     (mask_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   bit q[$];
   bit m_ov = 1'b0;
   int m_od = 0;

   typedef struct {
      int fd;
      int gi;
      int exp;
   } vec_t;
   vec_t tv[4];

   task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // one clock: drive, check combinational/registered outputs mid-cycle, advance model
   task automatic cyc(input bit fv, input int fd, input bit gv, input int gi, input bit gor, input bit clr);
      bit fr_e, gr_e;
      fwd_valid = fv;
      fwd_data = fd;
      grad_in_valid = gv;
      grad_in = 16'(gi);
      grad_out_ready = gor;
      clear = clr;
      fr_e = (q.size() != D) && !clr;
      gr_e = (q.size() != 0) && (!m_ov || gor) && !clr;
      @(negedge clk);
      chk("fwd_ready", 32'(fwd_ready), 32'(fr_e));
      chk("grad_in_ready", 32'(grad_in_ready), 32'(gr_e));
      chk("mask_count", 32'(mask_count), q.size());
      chk("grad_out_valid", 32'(grad_out_valid), 32'(m_ov));
      if (m_ov) chk("grad_out", grad_out, m_od);
      @(posedge clk);
      if (clr) begin
         q.delete();
         m_ov = 1'b0;
         m_od = 0;
      end else begin
         if (gv && gr_e) begin
            bit m;
            m = q.pop_front();
            m_ov = 1'b1;
            m_od = m ? int'($signed(16'(gi))) : 0;
         end else if (gor) begin
            m_ov = 1'b0;
         end
         if (fv && fr_e) q.push_back(fd > 0);
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
   endtask

   task automatic check_reset_state();
      chk("rst_count", 32'(mask_count), 0);
      chk("rst_valid", 32'(grad_out_valid), 0);
      chk("rst_grad_out", grad_out, 0);
      chk("rst_fwd_ready", 32'(fwd_ready), 0);
      chk("rst_grad_in_ready", 32'(grad_in_ready), 0);
   endtask

   function automatic int rand_grad();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   initial begin
      tv[0] = '{fd: 100, gi: 7, exp: 7};
      tv[1] = '{fd: -5,  gi: 7, exp: 0};
      tv[2] = '{fd: 0,   gi: 7, exp: 0};
      tv[3] = '{fd: 300, gi: 7, exp: 7};

      // reset state
      fwd_valid = 1'b1;
      grad_in_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_state();
      fwd_valid = 1'b0;
      grad_in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // basic masking table
      for (int i = 0; i < 4; i++) cyc(1, tv[i].fd, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, tv[i].gi, 1, 0);
         chk("tbl_valid", 32'(grad_out_valid), 1);
         chk("tbl_grad_out", grad_out, tv[i].exp);
      end
      idle(2);

      // fill to full, refused 17th, one pop reopens
      for (int i = 0; i < D; i++) cyc(1, 5 + i, 0, 0, 1, 0);
      chk("full_count", 32'(mask_count), D);
      chk("full_fwd_ready", 32'(fwd_ready), 0);
      cyc(1, 5, 0, 0, 1, 0);
      chk("full_no_17th", 32'(mask_count), D);
      cyc(0, 0, 1, 3, 1, 0);
      chk("reopen_fwd_ready", 32'(fwd_ready), 1);
      for (int i = 0; i < 2 * D && q.size() > 0; i++) cyc(0, 0, 1, 3, 1, 0);
      idle(2);

      // empty stall and no bypass
      cyc(0, 0, 1, 9, 1, 0);
      cyc(0, 0, 1, 9, 1, 0);
      chk("empty_no_valid", 32'(grad_out_valid), 0);
      cyc(1, 1, 1, 9, 1, 0);
      chk("no_bypass", 32'(grad_out_valid), 0);
      cyc(0, 0, 1, 9, 1, 0);
      chk("after_push_valid", 32'(grad_out_valid), 1);
      chk("after_push_data", grad_out, 9);
      idle(2);

      // backpressure hold
      cyc(1, 2, 0, 0, 1, 0);
      cyc(1, 2, 0, 0, 1, 0);
      cyc(0, 0, 1, -1234, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 55, 0, 0);
      chk("hold_data", grad_out, -1234);
      chk("hold_ready", 32'(grad_in_ready), 0);
      cyc(0, 0, 1, 55, 1, 0);
      chk("release_data", grad_out, 55);
      idle(2);

      // 40 through with simultaneous push/pop, pointers wrap
      for (int i = 0; i < 3; i++) cyc(1, int'($urandom_range(0, 200)) - 100, 0, 0, 1, 0);
      for (int i = 0; i < 37; i++)
         cyc(1, int'($urandom_range(0, 200)) - 100, 1, rand_grad(), 1, 0);
      chk("wrap_count", 32'(mask_count), 3);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, rand_grad(), 1, 0);
      idle(2);

      // clear with pending masks and output
      for (int i = 0; i < 6; i++) cyc(1, 10, 0, 0, 1, 0);
      cyc(0, 0, 1, 77, 0, 0);
      chk("pre_clear_count", 32'(mask_count), 5);
      cyc(0, 0, 0, 0, 0, 1);
      chk("clear_count", 32'(mask_count), 0);
      chk("clear_valid", 32'(grad_out_valid), 0);
      cyc(0, 0, 1, 5, 1, 0);
      cyc(0, 0, 1, 5, 1, 0);
      chk("clear_stall", 32'(grad_out_valid), 0);

      // reset mid-operation
      for (int i = 0; i < 6; i++) cyc(1, 10, 0, 0, 1, 0);
      cyc(0, 0, 1, 77, 0, 0);
      rst_n = 1'b0;
      #1;
      check_reset_state();
      q.delete();
      m_ov = 1'b0;
      m_od = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(0, 0, 1, 5, 1, 0);
      cyc(0, 0, 1, 5, 1, 0);
      chk("reset_stall", 32'(grad_out_valid), 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 400)) - 200,
             bit'($urandom_range(0, 1)), rand_grad(),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
